// File: rtl/vga_plot_arbiter.sv
// Purpose : shares the vga_adapter pixel-write port between the clean (0) and draw_box (1) engines.
// Latency : grant 1 cycle after request is sampled; accepted pixel appears on x/y/col/plot 1 cycle later.
// Backpressure: request/grant handshake, round-robin with a burst limit; off-screen pixels are dropped and counted.
//
// Ports:
//   clk, resetn                      clock, asynchronous active-low reset
//   req0/1, pix_valid0/1             level request per engine, pixel offered this cycle
//   x0/1, y0/1, col0/1               pixel offered by each engine
//   gnt0, gnt1                       registered ownership grant, never both high
//   x_out, y_out, col_out, plot      registered pixel write to the adapter, plot is a 1-cycle pulse
//   busy                             arbiter is granting or switching
//   drop_cnt                         saturating count of clipped pixels since reset
module vga_plot_arbiter #(
    parameter int X_W       = 8,
    parameter int Y_W       = 7,
    parameter int COL_W     = 3,
    parameter int X_MAX     = 160,
    parameter int Y_MAX     = 120,
    parameter int BURST_MAX = 64
) (
    input  logic             clk,
    input  logic             resetn,
    input  logic             req0,
    input  logic             req1,
    input  logic             pix_valid0,
    input  logic             pix_valid1,
    input  logic [X_W-1:0]   x0,
    input  logic [X_W-1:0]   x1,
    input  logic [Y_W-1:0]   y0,
    input  logic [Y_W-1:0]   y1,
    input  logic [COL_W-1:0] col0,
    input  logic [COL_W-1:0] col1,
    output logic             gnt0,
    output logic             gnt1,
    output logic [X_W-1:0]   x_out,
    output logic [Y_W-1:0]   y_out,
    output logic [COL_W-1:0] col_out,
    output logic             plot,
    output logic             busy,
    output logic [7:0]       drop_cnt
);

    localparam int CNT_W = $clog2(BURST_MAX) + 1;
    localparam int XW1   = X_W + 1;
    localparam int YW1   = Y_W + 1;

    localparam logic [CNT_W-1:0] BURST_LIM = CNT_W'(BURST_MAX);
    // One extra bit so a limit equal to 2**X_W (or 2**Y_W) still compares correctly.
    localparam logic [X_W:0]     X_LIM     = XW1'(X_MAX);
    localparam logic [Y_W:0]     Y_LIM     = YW1'(Y_MAX);

    typedef enum logic [1:0] {IDLE, GRANT0, GRANT1, SWITCH} state_t;

    state_t             state_q;
    logic               gnt0_q, gnt1_q;
    logic               last_q;      // 1: requester 1 owned the port last
    logic [CNT_W-1:0]   burst_q;
    logic [CNT_W-1:0]   burst_d;
    logic [X_W-1:0]     x_out_q;
    logic [Y_W-1:0]     y_out_q;
    logic [COL_W-1:0]   col_out_q;
    logic               plot_q;
    logic [7:0]         drop_q;

    logic               sel1;
    logic               acc;
    logic               on_screen;
    logic               own_req;
    logic               oth_req;
    logic               leave;
    logic               want0;
    logic [X_W-1:0]     px;
    logic [Y_W-1:0]     py;
    logic [COL_W-1:0]   pc;

    always_comb begin
        sel1      = (state_q == GRANT1);
        acc       = ((state_q == GRANT0) && pix_valid0) || ((state_q == GRANT1) && pix_valid1);
        px        = sel1 ? x1   : x0;
        py        = sel1 ? y1   : y0;
        pc        = sel1 ? col1 : col0;
        on_screen = ({1'b0, px} < X_LIM) && ({1'b0, py} < Y_LIM);
        own_req   = sel1 ? req1 : req0;
        oth_req   = sel1 ? req0 : req1;

        // Count saturates so a lone requester keeps the grant indefinitely.
        burst_d = burst_q;
        if (acc && (burst_q != BURST_LIM)) begin
            burst_d = burst_q + CNT_W'(1);
        end

        // The limit is judged on the count including this cycle's accept,
        // so a burst never exceeds BURST_MAX pixels while the other side waits.
        leave = !own_req || ((burst_d == BURST_LIM) && oth_req);

        // Same choice from IDLE and SWITCH: the requester that did not own last wins contention.
        want0 = req0 && (last_q || !req1);
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state_q   <= IDLE;
            gnt0_q    <= 1'b0;
            gnt1_q    <= 1'b0;
            last_q    <= 1'b1;
            burst_q   <= '0;
            x_out_q   <= '0;
            y_out_q   <= '0;
            col_out_q <= '0;
            plot_q    <= 1'b0;
            drop_q    <= '0;
        end else begin
            plot_q <= acc && on_screen;
            if (acc && on_screen) begin
                x_out_q   <= px;
                y_out_q   <= py;
                col_out_q <= pc;
            end
            if (acc && !on_screen && (drop_q != 8'hFF)) begin
                drop_q <= drop_q + 8'd1;
            end

            case (state_q)
                GRANT0, GRANT1: begin
                    burst_q <= burst_d;
                    if (leave) begin
                        last_q  <= sel1;
                        gnt0_q  <= 1'b0;
                        gnt1_q  <= 1'b0;
                        // SWITCH gives one dead cycle so the last plot pulse drains.
                        state_q <= oth_req ? SWITCH : IDLE;
                    end
                end
                default: begin
                    burst_q <= '0;
                    if (want0) begin
                        state_q <= GRANT0;
                        gnt0_q  <= 1'b1;
                    end else if (req1) begin
                        state_q <= GRANT1;
                        gnt1_q  <= 1'b1;
                    end else begin
                        state_q <= IDLE;
                    end
                end
            endcase
        end
    end

    assign gnt0     = gnt0_q;
    assign gnt1     = gnt1_q;
    assign x_out    = x_out_q;
    assign y_out    = y_out_q;
    assign col_out  = col_out_q;
    assign plot     = plot_q;
    assign busy     = (state_q != IDLE);
    assign drop_cnt = drop_q;

endmodule

// File: tb/tb_vga_plot_arbiter.sv
// Purpose : self-checking bench for vga_plot_arbiter against a transaction-level owner/burst model.
// Latency : model predicts every output one cycle after the inputs it was given.
// Backpressure: engines keep offering the head pixel of their queue until the model says it was taken.
module tb_vga_plot_arbiter;

    localparam int BMAX  = 4;
    localparam int XMAX  = 160;
    localparam int YMAX  = 120;

    typedef struct packed {
        logic [7:0] x;
        logic [6:0] y;
        logic [2:0] c;
    } pix_t;

    logic       clk;
    logic       resetn;
    logic       req0, req1, pv0, pv1;
    logic [7:0] x0, x1;
    logic [6:0] y0, y1;
    logic [2:0] col0, col1;
    logic       gnt0, gnt1, plot, busy;
    logic [7:0] x_out;
    logic [6:0] y_out;
    logic [2:0] col_out;
    logic [7:0] drop_cnt;

    vga_plot_arbiter #(
        .X_W(8), .Y_W(7), .COL_W(3), .X_MAX(XMAX), .Y_MAX(YMAX), .BURST_MAX(BMAX)
    ) dut (
        .clk(clk), .resetn(resetn),
        .req0(req0), .req1(req1), .pix_valid0(pv0), .pix_valid1(pv1),
        .x0(x0), .x1(x1), .y0(y0), .y1(y1), .col0(col0), .col1(col1),
        .gnt0(gnt0), .gnt1(gnt1), .x_out(x_out), .y_out(y_out), .col_out(col_out),
        .plot(plot), .busy(busy), .drop_cnt(drop_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    // Engine stimulus state
    pix_t        q0[$];
    pix_t        q1[$];
    pix_t        dmy;
    int unsigned vprob = 100;
    bit          early = 0;

    // Behavioural model: who owns the port, dead-cycle flag, pixels in this burst.
    int m_owner, m_last, m_burst, m_drop;
    bit m_gap, m_plot, m_acc0, m_acc1;
    int m_x, m_y, m_c;

    // Observations for the literal pins
    int n_plot, lx, ly, first_gnt, run_len;
    bit run_done;

    task automatic check(string nm, int act, int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s @%0t: got %0d expected %0d", nm, $time, act, exp);
        end
    endtask

    function automatic pix_t mk(int x, int y, int c);
        pix_t p;
        p.x = 8'(x);
        p.y = 7'(y);
        p.c = 3'(c);
        return p;
    endfunction

    task automatic model_reset();
        m_owner = -1; m_last = 1; m_burst = 0; m_drop = 0;
        m_gap = 0; m_plot = 0; m_acc0 = 0; m_acc1 = 0;
        m_x = 0; m_y = 0; m_c = 0;
    endtask

    task automatic model_step();
        int k, px, py, pc;
        bit rk, ro, v;
        m_acc0 = 0;
        m_acc1 = 0;
        if (!resetn) begin
            model_reset();
            return;
        end
        m_plot = 0;
        if (m_owner >= 0) begin
            k  = m_owner;
            rk = (k == 1) ? req1 : req0;
            ro = (k == 1) ? req0 : req1;
            v  = (k == 1) ? pv1  : pv0;
            px = (k == 1) ? int'(x1)   : int'(x0);
            py = (k == 1) ? int'(y1)   : int'(y0);
            pc = (k == 1) ? int'(col1) : int'(col0);
            if (v) begin
                if (k == 1) m_acc1 = 1; else m_acc0 = 1;
                if (m_burst < BMAX) m_burst++;
                if (px < XMAX && py < YMAX) begin
                    m_plot = 1; m_x = px; m_y = py; m_c = pc;
                end else if (m_drop < 255) begin
                    m_drop++;
                end
            end
            if (!rk || (m_burst == BMAX && ro)) begin
                m_last  = k;
                m_owner = -1;
                m_gap   = ro;
            end
        end else begin
            m_gap   = 0;
            m_burst = 0;
            if (req0 && req1) m_owner = 1 - m_last;
            else if (req0)    m_owner = 0;
            else if (req1)    m_owner = 1;
        end
    endtask

    task automatic compare();
        check("gnt0",     int'(gnt0), int'(m_owner == 0));
        check("gnt1",     int'(gnt1), int'(m_owner == 1));
        check("gnt_excl", int'(gnt0 & gnt1), 0);
        check("plot",     int'(plot), int'(m_plot));
        check("busy",     int'(busy), int'(m_owner >= 0 || m_gap));
        check("drop_cnt", int'(drop_cnt), m_drop);
        check("x_out",    int'(x_out), m_x);
        check("y_out",    int'(y_out), m_y);
        check("col_out",  int'(col_out), m_c);
    endtask

    task automatic drive();
        if (q0.size() > 0) begin
            req0 = 1'b1;
            pv0  = ($urandom_range(99) < vprob);
            x0 = q0[0].x; y0 = q0[0].y; col0 = q0[0].c;
            if (early && pv0 && q0.size() == 1 && $urandom_range(1) == 1) req0 = 1'b0;
        end else begin
            req0 = 1'b0; pv0 = 1'b0;
            x0 = 8'($urandom); y0 = 7'($urandom); col0 = 3'($urandom);
        end
        if (q1.size() > 0) begin
            req1 = 1'b1;
            pv1  = ($urandom_range(99) < vprob);
            x1 = q1[0].x; y1 = q1[0].y; col1 = q1[0].c;
            if (early && pv1 && q1.size() == 1 && $urandom_range(1) == 1) req1 = 1'b0;
        end else begin
            req1 = 1'b0; pv1 = 1'b0;
            x1 = 8'($urandom); y1 = 7'($urandom); col1 = 3'($urandom);
        end
    endtask

    task automatic cycle();
        @(posedge clk);
        model_step();
        @(negedge clk);
        compare();
        if (plot) begin
            n_plot++;
            lx = int'(x_out);
            ly = int'(y_out);
        end
        if (first_gnt < 0) begin
            if (gnt0) first_gnt = 0;
            else if (gnt1) first_gnt = 1;
        end
        if (gnt0 && !run_done) run_len++;
        else if (run_len > 0) run_done = 1;
        if (m_acc0) dmy = q0.pop_front();
        if (m_acc1) dmy = q1.pop_front();
        drive();
    endtask

    task automatic clear_obs();
        n_plot = 0; lx = -1; ly = -1; first_gnt = -1; run_len = 0; run_done = 0;
    endtask

    task automatic run_until_idle(string nm, int budget);
        int n = 0;
        while ((q0.size() > 0 || q1.size() > 0 || m_owner >= 0 || m_gap) && n < budget) begin
            cycle();
            n++;
        end
        check(nm, int'(n < budget), 1);
        repeat (2) cycle();
    endtask

    task automatic do_reset();
        resetn = 1'b0;
        #1;
        model_reset();
        repeat (2) cycle();
        resetn = 1'b1;
    endtask

    initial begin
        #900000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        resetn = 1'b0;
        req0 = 0; req1 = 0; pv0 = 0; pv1 = 0;
        x0 = 0; x1 = 0; y0 = 0; y1 = 0; col0 = 0; col1 = 0;
        model_reset();
        clear_obs();
        repeat (3) cycle();
        check("rst_busy", int'(busy), 0);
        check("rst_drop", int'(drop_cnt), 0);
        check("rst_plot", int'(plot), 0);
        resetn = 1'b1;

        // Single requester, four on-screen pixels
        clear_obs();
        for (int i = 0; i < 4; i++) q0.push_back(mk(10 + i, 20, 7));
        drive();
        run_until_idle("t1_done", 40);
        check("t1_plots", n_plot, 4);
        check("t1_last_x", lx, 13);
        check("t1_busy_after", int'(busy), 0);

        // Simultaneous requests right after reset: requester 0 first
        do_reset();
        clear_obs();
        for (int i = 0; i < 3; i++) q0.push_back(mk(40 + i, 50, 1));
        for (int i = 0; i < 3; i++) q1.push_back(mk(60 + i, 70, 2));
        drive();
        run_until_idle("t2_done", 60);
        check("t2_first_gnt", first_gnt, 0);
        check("t2_plots", n_plot, 6);

        // Burst limit: requester 0 yields after BMAX accepts while requester 1 waits
        do_reset();
        clear_obs();
        for (int i = 0; i < 10; i++) q0.push_back(mk(20 + i, 30, 5));
        for (int i = 0; i < 3; i++)  q1.push_back(mk(90 + i, 31, 6));
        drive();
        run_until_idle("t3_done", 80);
        check("t3_first_burst", run_len, BMAX);
        check("t3_plots", n_plot, 13);
        check("t3_last_x", lx, 29);

        // Clipping at the screen edges
        clear_obs();
        q0.push_back(mk(160, 5, 3));
        q0.push_back(mk(5, 120, 3));
        q0.push_back(mk(159, 119, 3));
        drive();
        run_until_idle("t4_done", 40);
        check("t4_plots", n_plot, 1);
        check("t4_drop", int'(drop_cnt), 2);
        check("t4_last_x", lx, 159);
        check("t4_last_y", ly, 119);

        // Drop counter saturation
        clear_obs();
        for (int i = 0; i < 300; i++) q0.push_back(mk(200, i % 128, 4));
        drive();
        run_until_idle("t5_done", 400);
        check("t5_drop_sat", int'(drop_cnt), 255);
        check("t5_plots", n_plot, 0);

        // Randomized traffic from both engines
        do_reset();
        early = 1;
        for (int it = 0; it < 40; it++) begin
            int nc;
            vprob = $urandom_range(100, 30);
            if ($urandom_range(1) == 1) begin
                nc = $urandom_range(8, 1);
                for (int i = 0; i < nc; i++)
                    q0.push_back(mk($urandom_range(180), $urandom_range(127), $urandom_range(7)));
            end
            if ($urandom_range(1) == 1) begin
                nc = $urandom_range(8, 1);
                for (int i = 0; i < nc; i++)
                    q1.push_back(mk($urandom_range(180), $urandom_range(127), $urandom_range(7)));
            end
            drive();
            repeat ($urandom_range(40, 5)) cycle();
        end
        run_until_idle("rand_done", 2000);

        // Reset mid-burst on requester 1
        early = 0;
        vprob = 100;
        clear_obs();
        for (int i = 0; i < 20; i++) q1.push_back(mk(70 + i, 80, 2));
        drive();
        begin
            int n = 0;
            while (!(m_owner == 1 && m_burst >= 2) && n < 20) begin
                cycle();
                n++;
            end
            check("t6_in_burst", int'(n < 20), 1);
        end
        check("t6_plot_before", int'(plot), 1);
        resetn = 1'b0;
        #1;
        check("t6_plot_rst", int'(plot), 0);
        check("t6_gnt1_rst", int'(gnt1), 0);
        check("t6_busy_rst", int'(busy), 0);
        check("t6_drop_rst", int'(drop_cnt), 0);
        model_reset();
        repeat (2) cycle();
        resetn = 1'b1;
        begin
            int n = 0;
            while (!gnt1 && n < 5) begin
                cycle();
                n++;
            end
            check("t6_regrant", int'(gnt1), 1);
        end
        run_until_idle("t6_done", 100);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/vga_plot_arbiter.md
Name: vga_plot_arbiter

Overview:
- Shares the single pixel-write port of the vga_adapter (x, y, col, plot) between two plotting engines: requester 0 = clean (erase old box), requester 1 = draw_box (draw new box).
- Grants whole bursts under a request/grant handshake with round-robin priority and a burst limit.
- Registers the winning pixel to the adapter and drops off-screen pixels.
- Sits between the clean/draw engines and vga0; master still sequences goClean/goDraw.

Parameters:
- X_W, 8, x coordinate width
- Y_W, 7, y coordinate width
- COL_W, 3, colour width (3 = 1 bit per channel)
- X_MAX, 160, screen width; pixels with x >= X_MAX are dropped
- Y_MAX, 120, screen height; pixels with y >= Y_MAX are dropped
- BURST_MAX, 64, pixels a grantee may write before yielding to a waiting requester

Ports:
- clk  in  1  system clock (CLOCK_50)
- resetn  in  1  asynchronous active-low reset (KEY[0])
- req0, req1  in  1 each  level request; held high for the whole burst
- pix_valid0, pix_valid1  in  1 each  pixel offered this cycle
- x0, x1  in  X_W each  pixel x
- y0, y1  in  Y_W each  pixel y
- col0, col1  in  COL_W each  pixel colour
- gnt0, gnt1  out  1 each  ownership grant; registered; never both high
- x_out  out  X_W  to vga_adapter x
- y_out  out  Y_W  to vga_adapter y
- col_out  out  COL_W  to vga_adapter col
- plot  out  1  to vga_adapter plot; one-cycle pulse per written pixel
- busy  out  1  high in any state other than IDLE
- drop_cnt  out  8  saturating count of clipped pixels since reset

Behaviour:
- Reset (async, resetn=0):
  - State IDLE.
  - gnt0 = gnt1 = 0, plot = 0, x_out/y_out/col_out = 0.
  - drop_cnt = 0, burst counter = 0, last_owner = 1, so requester 0 wins the first contention.
  - Reset mid-burst aborts the burst immediately. No pixel is emitted after resetn falls.
- States: IDLE, GRANT0, GRANT1, SWITCH.
- IDLE:
  - Only one req high: go to that GRANTk.
  - Both high: go to GRANT of the requester that is not last_owner.
  - gnt rises at the same edge as the state change, one cycle after req is sampled.
- GRANTk:
  - A pixel is accepted on any edge where gntk=1 and pix_validk=1.
  - pix_valid from the non-granted requester is ignored, not queued.
  - Each accepted pixel increments the burst counter (width clog2(BURST_MAX)+1).
  - On accept, if x < X_MAX and y < Y_MAX: x_out/y_out/col_out load the pixel and plot=1 for exactly the next cycle (latency 1).
  - Otherwise plot stays 0 and drop_cnt increments, saturating at 255.
  - Exit when reqk is sampled low: go to SWITCH if the other req is high, else IDLE. last_owner := k.
  - Exit when burst counter == BURST_MAX and the other req is high: revoke gntk and go to SWITCH. last_owner := k. Requester k keeps req high and is re-granted later.
  - If the other requester is idle, the burst counter saturates and the grant continues indefinitely.
  - A pixel offered in the same cycle req drops is accepted (gnt still high).
- SWITCH:
  - One dead cycle with both gnt low. This lets the final plot pulse drain.
  - Next state is GRANT of the requester that is not last_owner if its req is high; else GRANT of the other requester if its req is high; else IDLE.
  - Burst counter clears.
- plot deasserts every cycle with no accept. Back-to-back accepts give consecutive plot pulses with no gap.
- busy = (state != IDLE).

Test Plan:
- Reset, then req0 only, 4 pixels (10,20),(11,20),(12,20),(13,20) col 3'b111 then req0 low -> gnt0 high 1 cycle after req0; 4 consecutive plot pulses, each 1 cycle after its accept, with matching x/y/col; IDLE after; busy low.
- req0 and req1 rise together after reset -> gnt0 first (last_owner=1); after req0 drops: one SWITCH cycle with both gnt low, then gnt1; gnt0 and gnt1 never high together.
- BURST_MAX=4; req0 streams 10 pixels, req1 high from start -> gnt0 drops after 4th accept; SWITCH; gnt1 served until req1 low; then gnt0 resumes, 6 remaining pixels all plotted.
- Pixels (160,5), (5,120), (159,119) -> only (159,119) plotted; drop_cnt=2.
- 300 off-screen pixels -> drop_cnt saturates at 255.
- resetn pulled low mid-burst on GRANT1 with pix_valid1 high -> plot, gnt1 and busy low immediately (async); drop_cnt=0; after release, req1 still high -> gnt1 re-granted from IDLE.
